// File: rtl/wb_pkg.sv
// wb_pkg: shared types, defaults and the hazard-compare helper for the writeback commit unit.
package wb_pkg;
  localparam int WB_XLEN  = 32;
  localparam int WB_NREGS = 8;
  localparam int WB_AW    = $clog2(WB_NREGS);
  localparam int QDEPTH   = 2;
  typedef struct packed {
    logic [WB_AW-1:0]   rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;
  function automatic logic hazard(input logic [WB_AW-1:0] addr, input logic [QDEPTH-1:0] vld,
                                  input logic [WB_AW-1:0] rd0, input logic [WB_AW-1:0] rd1);
    return (addr != '0) && ((vld[0] && rd0 == addr) || (vld[1] && rd1 == addr));
  endfunction
endpackage

// File: rtl/wb_queue2.sv
// wb_queue2: 2-entry in-order FIFO; exposes the head entry and age-ordered valids/rds.
module wb_queue2 import wb_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  wb_entry_t         i_din,
  input  logic              i_pop,
  output wb_entry_t         o_head,
  output logic [QDEPTH-1:0] o_vld,
  output logic [WB_AW-1:0]  o_rd0,
  output logic [WB_AW-1:0]  o_rd1,
  output logic [1:0]        o_count
);
  wb_entry_t  r_mem [QDEPTH];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= '{default: '0};
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_din;
        r_tail        <= ~r_tail;
      end
      if (i_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  // index 0 is always the oldest entry, index 1 the younger one
  assign o_head  = r_mem[r_head];
  assign o_rd0   = r_mem[r_head].rd;
  assign o_rd1   = r_mem[~r_head].rd;
  assign o_vld   = {r_cnt == 2'd2, r_cnt != 2'd0};
  assign o_count = r_cnt;
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: buffers ex results in a 2-entry queue, commits them to the register file,
// and serves two forwarded read ports with pending-write hazard flags.
module wb_commit_unit import wb_pkg::*; #(
  parameter int XLEN  = WB_XLEN,
  parameter int NREGS = WB_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_wbv,
  input  logic            commit_en,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_pending,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_pending,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data
);
  wb_entry_t         w_head;
  logic [QDEPTH-1:0] w_vld;
  logic [QDEPTH-1:0] w_hvld;
  logic [AW-1:0]     w_rd0;
  logic [AW-1:0]     w_rd1;
  logic [1:0]        w_count;
  logic              w_push;
  logic              w_fire;
  logic [XLEN-1:0]   r_rf [NREGS];
  logic              r_wb_valid;
  logic [AW-1:0]     r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  assign ex_ready = w_count != 2'd2;
  assign w_push   = ex_valid & ex_ready;
  assign w_fire   = commit_en & (w_count != 2'd0);
  wb_queue2 u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ('{rd: ex_rd, data: ex_wbv}),
    .i_pop   (w_fire),
    .o_head  (w_head),
    .o_vld   (w_vld),
    .o_rd0   (w_rd0),
    .o_rd1   (w_rd1),
    .o_count (w_count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf       <= '{default: '0};
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      if (w_fire && w_head.rd != '0) r_rf[w_head.rd] <= w_head.data;
      r_wb_valid <= w_fire;
      if (w_fire) begin
        r_wb_rd   <= w_head.rd;
        r_wb_data <= w_head.data;
      end
    end
  end
  // a firing head is no longer pending, but a younger write to the same rd still is
  assign w_hvld      = {w_vld[1], w_vld[0] & ~w_fire};
  assign rs1_pending = hazard(rs1_addr, w_hvld, w_rd0, w_rd1);
  assign rs2_pending = hazard(rs2_addr, w_hvld, w_rd0, w_rd1);
  assign rs1_data    = (rs1_addr == '0) ? '0 : (w_fire && w_head.rd == rs1_addr) ? w_head.data : r_rf[rs1_addr];
  assign rs2_data    = (rs2_addr == '0) ? '0 : (w_fire && w_head.rd == rs2_addr) ? w_head.data : r_rf[rs2_addr];
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed vector table, reset/back-to-back sequences and random traffic
// checked against a queue-based model of the commit unit.
module tb_wb_commit_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [2:0]  ex_rd = '0;
  logic [31:0] ex_wbv = '0;
  logic        commit_en = 1'b0;
  logic [2:0]  rs1_addr = '0;
  logic [31:0] rs1_data;
  logic        rs1_pending;
  logic [2:0]  rs2_addr = '0;
  logic [31:0] rs2_data;
  logic        rs2_pending;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  wb_commit_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_wbv(ex_wbv), .commit_en(commit_en), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
    .rs1_pending(rs1_pending), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .rs2_pending(rs2_pending), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic v; logic [2:0] rd; logic [31:0] wbv; logic ce; logic [2:0] a1; logic [2:0] a2;
    logic rdy; logic [31:0] r1d; logic r1p; logic r2p; logic wv; logic [2:0] wrd; logic [31:0] wd;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t mk(input logic v, input logic [2:0] rd, input logic [31:0] wbv,
                              input logic ce, input logic [2:0] a1, input logic [2:0] a2,
                              input logic rdy, input logic [31:0] r1d, input logic r1p,
                              input logic r2p, input logic wv, input logic [2:0] wrd,
                              input logic [31:0] wd);
    return '{v, rd, wbv, ce, a1, a2, rdy, r1d, r1p, r2p, wv, wrd, wd};
  endfunction

  typedef struct { logic [2:0] rd; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] mrf[8];
  logic        mwv;
  logic [2:0]  mwrd;
  logic [31:0] mwd;
  logic        m_fire;
  logic        m_push;

  task automatic m_reset();
    mq.delete();
    foreach (mrf[i]) mrf[i] = '0;
    mwv = 1'b0; mwrd = '0; mwd = '0;
  endtask

  function automatic logic [31:0] m_data(input logic [2:0] a, input logic f);
    if (a == 3'd0) return 32'd0;
    if (f) if (mq[0].rd == a) return mq[0].d;
    return mrf[a];
  endfunction

  function automatic logic m_pend(input logic [2:0] a, input logic f);
    if (a == 3'd0) return 1'b0;
    foreach (mq[i]) if ((i > 0 || !f) && mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // one clock cycle: drive at posedge+1, compare at negedge, advance model at posedge
  task automatic run_cycle(input logic v, input logic [2:0] rd, input logic [31:0] wbv,
                           input logic ce, input logic [2:0] a1, input logic [2:0] a2, input int ti);
    ent_t e;
    ex_valid = v; ex_rd = rd; ex_wbv = wbv; commit_en = ce; rs1_addr = a1; rs2_addr = a2;
    @(negedge clk);
    m_fire = ce && mq.size() > 0;
    m_push = v && mq.size() < 2;
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, mq.size() < 2});
    chk("rs1_data", rs1_data, m_data(a1, m_fire));
    chk("rs2_data", rs2_data, m_data(a2, m_fire));
    chk("rs1_pending", {31'd0, rs1_pending}, {31'd0, m_pend(a1, m_fire)});
    chk("rs2_pending", {31'd0, rs2_pending}, {31'd0, m_pend(a2, m_fire)});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, mwv});
    chk("wb_rd", {29'd0, wb_rd}, {29'd0, mwrd});
    chk("wb_data", wb_data, mwd);
    if (ti >= 0) begin
      chk($sformatf("row%0d ready", ti), {31'd0, ex_ready}, {31'd0, tbl[ti].rdy});
      chk($sformatf("row%0d rs1_data", ti), rs1_data, tbl[ti].r1d);
      chk($sformatf("row%0d rs1_pending", ti), {31'd0, rs1_pending}, {31'd0, tbl[ti].r1p});
      chk($sformatf("row%0d rs2_pending", ti), {31'd0, rs2_pending}, {31'd0, tbl[ti].r2p});
      chk($sformatf("row%0d wb_valid", ti), {31'd0, wb_valid}, {31'd0, tbl[ti].wv});
      chk($sformatf("row%0d wb_rd", ti), {29'd0, wb_rd}, {29'd0, tbl[ti].wrd});
      chk($sformatf("row%0d wb_data", ti), wb_data, tbl[ti].wd);
    end
    @(posedge clk);
    if (m_fire) begin
      e = mq.pop_front();
      if (e.rd != 3'd0) mrf[e.rd] = e.d;
      mwrd = e.rd;
      mwd  = e.d;
    end
    mwv = m_fire;
    if (m_push) mq.push_back('{rd, wbv});
    #1;
  endtask

  initial begin
    m_reset();
    //               v  rd  wbv           ce a1 a2  rdy r1d           r1p r2p wv wrd wd
    tbl[0]  = mk(1, 3, 32'hDEADBEEF, 1, 3, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,        1, 3, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 3, 0, 1, 32'hDEADBEEF, 0, 0, 1, 3, 32'hDEADBEEF);
    tbl[3]  = mk(1, 1, 32'h11,       0, 1, 2, 1, 32'h0,        0, 0, 0, 3, 32'hDEADBEEF);
    tbl[4]  = mk(1, 2, 32'h22,       0, 1, 2, 1, 32'h0,        1, 0, 0, 3, 32'hDEADBEEF);
    tbl[5]  = mk(1, 7, 32'h77,       0, 1, 2, 0, 32'h0,        1, 1, 0, 3, 32'hDEADBEEF);
    tbl[6]  = mk(0, 0, 32'h0,        1, 1, 2, 0, 32'h11,       0, 1, 0, 3, 32'hDEADBEEF);
    tbl[7]  = mk(0, 0, 32'h0,        1, 1, 2, 1, 32'h11,       0, 0, 1, 1, 32'h11);
    tbl[8]  = mk(0, 0, 32'h0,        0, 2, 1, 1, 32'h22,       0, 0, 1, 2, 32'h22);
    tbl[9]  = mk(1, 5, 32'hA,        0, 5, 5, 1, 32'h0,        0, 0, 0, 2, 32'h22);
    tbl[10] = mk(1, 5, 32'hB,        0, 5, 5, 1, 32'h0,        1, 1, 0, 2, 32'h22);
    tbl[11] = mk(0, 0, 32'h0,        1, 5, 5, 0, 32'hA,        1, 1, 0, 2, 32'h22);
    tbl[12] = mk(0, 0, 32'h0,        1, 5, 5, 1, 32'hB,        0, 0, 1, 5, 32'hA);
    tbl[13] = mk(0, 0, 32'h0,        0, 5, 5, 1, 32'hB,        0, 0, 1, 5, 32'hB);
    tbl[14] = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h0,        0, 0, 0, 5, 32'hB);
    tbl[15] = mk(0, 0, 32'h0,        1, 0, 0, 1, 32'h0,        0, 0, 0, 5, 32'hB);
    tbl[16] = mk(0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        0, 0, 1, 0, 32'hFFFFFFFF);
    tbl[17] = mk(0, 0, 32'h0,        0, 5, 7, 1, 32'hB,        0, 0, 0, 0, 32'hFFFFFFFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 18; i++)
      run_cycle(tbl[i].v, tbl[i].rd, tbl[i].wbv, tbl[i].ce, tbl[i].a1, tbl[i].a2, i);

    // reset with two entries still queued
    run_cycle(1, 4, 32'h44, 0, 4, 6, -1);
    run_cycle(1, 6, 32'h66, 0, 4, 6, -1);
    ex_valid = 1'b0; commit_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst rs1_pending", {31'd0, rs1_pending}, 32'd0);
    chk("rst rs2_pending", {31'd0, rs2_pending}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      rs1_addr = a[2:0];
      #1 chk($sformatf("rst rs1_data[%0d]", a), rs1_data, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 1, 4, 6, -1);

    // back-to-back push and commit at count 1
    run_cycle(1, 1, 32'd100, 0, 1, 2, -1);
    for (int k = 0; k < 10; k++) begin
      run_cycle(1, 3'(k % 7 + 1), 32'd200 + k, 1, 3'(k % 7 + 1), 3'(k % 7), -1);
      chk("b2b ready", {31'd0, ex_ready}, 32'd1);
    end
    run_cycle(0, 0, 0, 1, 1, 2, -1);
    run_cycle(0, 0, 0, 1, 3, 4, -1);

    for (int i = 0; i < 400; i++)
      run_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Writeback end of the ex→wb pipeline: accepts execute-stage results (destination register plus writeback value) over a valid/ready handshake.
- Buffers results in a 2-entry in-order queue and commits them to an architectural register file when `commit_en` is high.
- Serves two combinational read ports with commit-forwarding, plus pending-hazard flags for the decode stage.

Parameters:
- XLEN, 32, width of writeback data.
- NREGS, 8, number of architectural registers (power of two, ≥2).
- AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  execute result valid.
- ex_ready  output  1  queue can accept a result.
- ex_rd  input  AW  destination register.
- ex_wbv  input  XLEN  writeback value.
- commit_en  input  1  permits committing the queue head this cycle.
- rs1_addr  input  AW  read port 1 address.
- rs1_data  output  XLEN  read port 1 data.
- rs1_pending  output  1  rs1 has an uncommitted write queued.
- rs2_addr  input  AW  read port 2 address.
- rs2_data  output  XLEN  read port 2 data.
- rs2_pending  output  1  rs2 has an uncommitted write queued.
- wb_valid  output  1  registered commit strobe.
- wb_rd  output  AW  register committed at previous edge.
- wb_data  output  XLEN  value committed at previous edge.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Queue emptied (count=0, pointers=0).
  - All registers cleared to 0.
  - wb_valid=0, wb_rd=0, wb_data=0.
  - Queue contents in flight at reset are discarded; no commit occurs.
- Handshake:
  - push = ex_valid & ex_ready.
  - ex_ready = (count != 2), derived from registered count only; never depends on ex_valid or commit_en.
  - ex_rd/ex_wbv are sampled only on push. ex_valid while not ready has no effect; the producer holds its data.
- Commit:
  - fire = commit_en & (count != 0).
  - On fire, the head entry is written to regfile[head.rd] at the edge and the head pointer advances.
  - rd==0: the regfile is not modified (x0 reads 0 always), but the commit still counts and raises wb_valid.
- Simultaneous push and fire: allowed at count 1. Count is unchanged; order is preserved. At count 0, push and fire cannot both act; the new entry commits no earlier than the next cycle.
- Latency: a result pushed at edge N is committed at edge N+1 at the earliest (queue empty, commit_en high in cycle N+1). wb_valid/wb_rd/wb_data show that commit during cycle N+2.
- Registered outputs: wb_valid=fire registered each cycle. wb_rd/wb_data load only on fire and hold otherwise.
- Read ports (combinational), rsX_data:
  - addr==0 → 0.
  - Else if fire and head.rd==addr → head.data (commit forward).
  - Else regfile[addr].
- Pending flags: rsX_pending = addr!=0 and some valid queue entry has rd==addr, excluding the head entry when it fires this cycle.
  - If both entries match, pending stays 1 even if the head fires.
  - Forwarding and pending are evaluated independently: the older value is forwarded while pending still flags the younger write.
- Ordering: two queued writes to the same rd commit oldest first; the final regfile value is the younger one.
- Pointer wrap: 1-bit head/tail pointers wrap 1→0. Count is held in 2 bits (0..2).

Decomposition:
- Shared package `wb_pkg`:
  - XLEN/NREGS defaults.
  - Typedef `wb_entry_t` {rd[AW], data[XLEN]}.
  - Localparam QDEPTH=2.
- One natural sub-module `wb_queue2`: 2-entry in-order FIFO exposing the head entry, both entry valids/rds for hazard compare, push/pop, and count.
- Regfile, forwarding, pending logic and output registers stay in `wb_commit_unit`.

Test Plan:
- Reset mid-operation: queue 2 entries with commit_en=0, assert rst_n=0 for 1 cycle → ex_ready=1, wb_valid=0, rs1_data=0 for every address; no write appears afterwards.
- Basic latency: push rd=3, wbv=0xDEAD_BEEF at edge N with commit_en=1 → wb_valid=1, wb_rd=3, wb_data=0xDEADBEEF in cycle N+2; rs1_addr=3 reads 0xDEADBEEF from N+2 and via forward during cycle N+1.
- Full/backpressure: commit_en=0, push rd=1 (0x11) and rd=2 (0x22) → ex_ready=0, rs1_pending(addr 1)=1, rs2_pending(addr 2)=1; raise commit_en → 0x11 then 0x22 commit on consecutive edges, ex_ready returns to 1 one cycle after the first commit.
- Same-rd ordering: queue rd=5 ← 0xA then rd=5 ← 0xB, commit both → wb_data sequence 0xA, 0xB; regfile[5]=0xB; rs1_pending(addr 5) stays 1 during the first commit and drops after the second.
- x0 write: push rd=0, wbv=0xFFFF_FFFF → wb_valid=1, wb_rd=0; rs1_data(addr 0)=0 throughout; rs1_pending(addr 0)=0 always.
- Simultaneous push/commit at count 1 for 10 back-to-back results → one commit per cycle, ex_ready continuously 1, values committed in push order.
